// File: rtl/simple_axi_read_arb_pkg.sv
// Shared types and helpers for the simple AXI read arbiter.
// Optional build macro used by the arbiter: SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN.
package simple_axi_read_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    REST = 2'd2
  } arb_state_t;

  // Grant index width, never narrower than one bit so N_REQ=1 still has a port.
  function automatic int unsigned idx_width(input int unsigned n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/simple_read_rr_arbiter.sv
// Combinational request picker: round-robin from ptr upward with wrap-around,
// or lowest-index-wins when SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN is defined.
module simple_read_rr_arbiter
  import simple_axi_read_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic        found;
  int unsigned k;

`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = i;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`else
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = (32'(ptr) + i) % N_REQ;
      if (!found && req[k]) begin
        found     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/simple_axi_read_arbiter.sv
// Shares one simple-read adapter port between N_REQ requesters, one whole transfer per grant.
// Build option: SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module simple_axi_read_arbiter
  import simple_axi_read_arb_pkg::*;
#(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 32,
  parameter int unsigned LEN_W      = 8,
  localparam int unsigned IDX_W     = idx_width(N_REQ)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_rvalid_i,
  input  logic [N_REQ*AXI_ADDR_W-1:0] req_raddr_i,
  input  logic [N_REQ*LEN_W-1:0]      req_rlen_i,
  output logic [N_REQ-1:0]            req_rready_o,
  output logic [AXI_DATA_W-1:0]       req_rdata_o,
  output logic [N_REQ-1:0]            req_rlast_o,
  output logic                        m_rvalid_o,
  output logic [AXI_ADDR_W-1:0]       m_raddr_o,
  output logic [LEN_W-1:0]            m_rlen_o,
  input  logic                        m_rready_i,
  input  logic [AXI_DATA_W-1:0]       m_rdata_i,
  input  logic                        m_rlast_i,
  output logic                        busy_o,
  output logic [IDX_W-1:0]            grant_idx_o
);

  arb_state_t state, state_nxt;
  logic [IDX_W-1:0] grant_idx, grant_nxt;
  logic [IDX_W-1:0] arb_ptr, arb_idx;
  logic [N_REQ-1:0] arb_grant;

  logic                  in_busy;
  logic                  sel_valid;
  logic [AXI_ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]      sel_len;
  logic                  beat;
  logic                  xfer_done;

  simple_read_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req       (req_rvalid_i),
    .ptr       (arb_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr, rr_nxt;

  always_comb begin
    rr_nxt = rr_ptr;
    if (xfer_done)
      rr_nxt = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rr_ptr <= '0;
    else        rr_ptr <= rr_nxt;
  end

  assign arb_ptr = rr_ptr;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      grant_idx <= '0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    case (state)
      IDLE: begin
        // Requests are only looked at here; anything arriving in BUSY/REST waits.
        if (|arb_grant) begin
          grant_nxt = arb_idx;
          state_nxt = BUSY;
        end
      end
      BUSY:    if (xfer_done) state_nxt = REST;
      REST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_busy = (state == BUSY);

  // Mux the granted requester's request down and steer the adapter handshake back up.
  always_comb begin
    sel_valid    = 1'b0;
    sel_addr     = '0;
    sel_len      = '0;
    req_rready_o = '0;
    req_rlast_o  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (IDX_W'(k) == grant_idx) begin
        sel_valid = req_rvalid_i[k];
        sel_addr  = req_raddr_i[k*AXI_ADDR_W +: AXI_ADDR_W];
        sel_len   = req_rlen_i[k*LEN_W +: LEN_W];
        if (in_busy) begin
          req_rready_o[k] = m_rready_i;
          req_rlast_o[k]  = m_rready_i & m_rlast_i;
        end
      end
    end
  end

  // The adapter holds rlast high while idle, so last only counts on a consumed beat.
  assign beat      = in_busy & m_rready_i & sel_valid;
  assign xfer_done = beat & m_rlast_i;

  assign m_rvalid_o  = in_busy & sel_valid;
  assign m_raddr_o   = in_busy ? sel_addr : '0;
  assign m_rlen_o    = in_busy ? sel_len : '0;
  assign req_rdata_o = m_rdata_i;
  assign busy_o      = (state != IDLE);
  assign grant_idx_o = grant_idx;

  a_len_nonzero : assert property (
    @(posedge clk_i) disable iff (!rst_i)
    (in_busy && sel_valid) |-> (sel_len != '0)
  ) else $error("zero-length read request on granted port %0d", grant_idx);

endmodule

// File: tb/tb_simple_axi_read_arbiter.sv
// Directed bench for simple_axi_read_arbiter (N_REQ=2); expectations follow
// SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN when defined.
module tb_simple_axi_read_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 8;
  localparam int unsigned IW = 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [N-1:0]      req_rvalid_i;
  logic [N*AW-1:0]   req_raddr_i;
  logic [N*LW-1:0]   req_rlen_i;
  logic [N-1:0]      req_rready_o;
  logic [DW-1:0]     req_rdata_o;
  logic [N-1:0]      req_rlast_o;
  logic              m_rvalid_o;
  logic [AW-1:0]     m_raddr_o;
  logic [LW-1:0]     m_rlen_o;
  logic              m_rready_i;
  logic [DW-1:0]     m_rdata_i;
  logic              m_rlast_i;
  logic              busy_o;
  logic [IW-1:0]     grant_idx_o;

  int n_tests = 0;
  int n_fail  = 0;

  simple_axi_read_arbiter #(
    .N_REQ      (N),
    .AXI_ADDR_W (AW),
    .AXI_DATA_W (DW),
    .LEN_W      (LW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_rvalid_i (req_rvalid_i),
    .req_raddr_i  (req_raddr_i),
    .req_rlen_i   (req_rlen_i),
    .req_rready_o (req_rready_o),
    .req_rdata_o  (req_rdata_o),
    .req_rlast_o  (req_rlast_o),
    .m_rvalid_o   (m_rvalid_o),
    .m_raddr_o    (m_raddr_o),
    .m_rlen_o     (m_rlen_o),
    .m_rready_i   (m_rready_i),
    .m_rdata_i    (m_rdata_i),
    .m_rlast_i    (m_rlast_i),
    .busy_o       (busy_o),
    .grant_idx_o  (grant_idx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    req_raddr_i[k*AW +: AW] = addr;
    req_rlen_i[k*LW +: LW]  = len;
  endtask

  task automatic do_reset();
    rst_i        = 1'b0;
    req_rvalid_i = '0;
    m_rready_i   = 1'b0;
    m_rlast_i    = 1'b1;
    tick();
    tick();
    rst_i = 1'b1;
  endtask

  // Entered just after an edge with state IDLE and requests set; returns just after
  // the edge that lands back in IDLE.
  task automatic xfer(input int g, input int nb, input logic [AW-1:0] addr,
                      input logic [LW-1:0] len);
    logic [N-1:0] one;
    one    = '0;
    one[g] = 1'b1;
    tick();
    #1;
    chk("grant_idx", 64'(grant_idx_o), 64'(g));
    chk("m_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("m_raddr", 64'(m_raddr_o), 64'(addr));
    chk("m_rlen", 64'(m_rlen_o), 64'(len));
    for (int b = 0; b < nb; b++) begin
      m_rready_i = 1'b1;
      m_rdata_i  = 32'hD000_0000 + 32'(b);
      m_rlast_i  = (b == nb - 1);
      #1;
      chk("beat_rready", 64'(req_rready_o), 64'(one));
      chk("beat_rlast", 64'(req_rlast_o), (b == nb - 1) ? 64'(one) : 64'd0);
      chk("beat_rdata", 64'(req_rdata_o), 64'(32'hD000_0000 + 32'(b)));
      tick();
    end
    m_rready_i = 1'b0;
    m_rlast_i  = 1'b1;
    #1;
    chk("rest_busy", 64'(busy_o), 64'd1);
    chk("rest_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rest_rlast", 64'(req_rlast_o), 64'd0);
    tick();
    #1;
    chk("idle_busy", 64'(busy_o), 64'd0);
  endtask

  int exp_order [4];

  initial begin
    req_raddr_i = '0;
    req_rlen_i  = '0;
    m_rdata_i   = '0;
    do_reset();
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("rst_grant", 64'(grant_idx_o), 64'd0);
    chk("rst_rready", 64'(req_rready_o), 64'd0);
    chk("rst_rlast", 64'(req_rlast_o), 64'd0);
    chk("rst_raddr", 64'(m_raddr_o), 64'd0);
    m_rdata_i = 32'hA5A5_0001;
    #1;
    chk("rdata_mirror", 64'(req_rdata_o), 64'h0000_0000_A5A5_0001);

    // Single request: 4 beats from 0x100, 16 bytes.
    set_req(0, 32'h100, 8'd16);
    req_rvalid_i = 2'b01;
    #1;
    chk("latency_rvalid", 64'(m_rvalid_o), 64'd0);
    xfer(0, 4, 32'h100, 8'd16);
    req_rvalid_i = '0;
    tick();
    #1;
    chk("single_stays_idle", 64'(busy_o), 64'd0);
    chk("single_idle_rvalid", 64'(m_rvalid_o), 64'd0);

    // Both requesters continuously valid over four back-to-back transfers.
    do_reset();
    set_req(0, 32'h100, 8'd16);
    set_req(1, 32'h200, 8'd8);
`ifdef SIMPLE_AXI_READ_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0};
`else
    exp_order = '{0, 1, 0, 1};
`endif
    req_rvalid_i = 2'b11;
    for (int i = 0; i < 4; i++)
      xfer(exp_order[i], 2, (exp_order[i] == 0) ? 32'h100 : 32'h200,
           (exp_order[i] == 0) ? 8'd16 : 8'd8);
    req_rvalid_i = '0;
    tick();

    // Idle-last filter then requester stall in the middle of a 4-beat transfer.
    do_reset();
    set_req(0, 32'h300, 8'd16);
    req_rvalid_i = 2'b01;
    tick();
    m_rready_i = 1'b0;
    m_rlast_i  = 1'b1;
    #1;
    chk("filt_rlast", 64'(req_rlast_o), 64'd0);
    chk("filt_rvalid", 64'(m_rvalid_o), 64'd1);
    tick();
    #1;
    chk("filt_hold_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("filt_hold_rlast", 64'(req_rlast_o), 64'd0);
    m_rready_i = 1'b1;
    m_rlast_i  = 1'b0;
    tick();
    for (int s = 0; s < 3; s++) begin
      req_rvalid_i = 2'b00;
      m_rready_i   = (s == 2);
      m_rlast_i    = (s == 2);
      #1;
      chk("stall_rvalid", 64'(m_rvalid_o), 64'd0);
      chk("stall_grant", 64'(grant_idx_o), 64'd0);
      chk("stall_busy", 64'(busy_o), 64'd1);
      tick();
    end
    req_rvalid_i = 2'b01;
    for (int b = 2; b <= 4; b++) begin
      m_rready_i = 1'b1;
      m_rlast_i  = (b == 4);
      #1;
      chk("resume_rvalid", 64'(m_rvalid_o), 64'd1);
      chk("resume_rlast", 64'(req_rlast_o), (b == 4) ? 64'd1 : 64'd0);
      tick();
    end
    m_rready_i   = 1'b0;
    req_rvalid_i = '0;
    #1;
    chk("stall_rest_busy", 64'(busy_o), 64'd1);
    chk("stall_rest_rvalid", 64'(m_rvalid_o), 64'd0);
    tick();
    #1;
    chk("stall_idle_busy", 64'(busy_o), 64'd0);

    // Reset during beat 2 of a transfer owned by requester 1.
    do_reset();
    set_req(0, 32'h100, 8'd16);
    set_req(1, 32'h200, 8'd8);
    req_rvalid_i = 2'b10;
    tick();
    #1;
    chk("mid_grant1", 64'(grant_idx_o), 64'd1);
    m_rready_i = 1'b1;
    m_rlast_i  = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    #1;
    chk("mid_rst_busy", 64'(busy_o), 64'd0);
    chk("mid_rst_rvalid", 64'(m_rvalid_o), 64'd0);
    chk("mid_rst_grant", 64'(grant_idx_o), 64'd0);
    chk("mid_rst_rready", 64'(req_rready_o), 64'd0);
    chk("mid_rst_rlast", 64'(req_rlast_o), 64'd0);
    chk("mid_rst_raddr", 64'(m_raddr_o), 64'd0);
    chk("mid_rst_rlen", 64'(m_rlen_o), 64'd0);
    rst_i        = 1'b1;
    m_rready_i   = 1'b0;
    req_rvalid_i = 2'b11;
    tick();
    #1;
    chk("post_rst_grant", 64'(grant_idx_o), 64'd0);
    chk("post_rst_raddr", 64'(m_raddr_o), 64'h100);
    req_rvalid_i = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
